vend_service_arbiter: RTL
=========================

# vend_service_arbiter

Shares one product-dispense motor and one coin-return hopper among up to N vending-machine coin/selection FSMs. Each FSM raises a service request carrying a vend flag and a 2-bit change count (same 0–3 coin encoding as the FSM `change` output). The arbiter grants requesters round-robin and sequences the motor pulse, then the hopper coin pulses. It signals completion back to the requester.

## Interface
- `N_REQ`, 4: number of requesters (2–8).
- `DISP_CYC`, 8: motor_on high time per vend, in cycles (≥1).
- `COIN_CYC`, 4: hopper_on high time per coin (≥1).
- `GAP_CYC`, 2: hopper_on low time after each coin (≥1).
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low (`rst`=0 resets).
- `req`, in, N_REQ: service request per requester; held until its `done`.
- `vend`, in, N_REQ: bit i = 1 means dispense one product for requester i.
- `chg`, in, 2*N_REQ: coins to return; requester i uses bits [2i+1:2i], value 0–3.
- `grant`, out, N_REQ: one-hot; requester currently being served; 0 when idle.
- `done`, out, N_REQ: one-cycle pulse on the served requester's bit at end of service.
- `motor_on`, out, 1: dispense motor drive.
- `hopper_on`, out, 1: coin hopper drive.
- `busy`, out, 1: high in every state except IDLE.

## Operation
- FSM states: IDLE, DISPENSE, PAYOUT_ON, PAYOUT_GAP, DONE.
- Reset: state IDLE, pointer 0, all counters 0. Outputs `grant`, `done`, `motor_on`, `hopper_on` and `busy` are all 0, and are forced to 0 immediately on `rst` falling, mid-service included. A service aborted by reset is not resumed.
- IDLE: with any `req` bit high, pick the first set bit searching from pointer upward with wrap.
  - Latch winner index w, `vend[w]` and `chg[w]` into internal registers.
  - Next state: DISPENSE if the vend flag is 1; else PAYOUT_ON if coins > 0; else DONE.
- DISPENSE: `motor_on`=1 for exactly DISP_CYC cycles. Then PAYOUT_ON if coins > 0, else DONE.
- PAYOUT_ON: `hopper_on`=1 for COIN_CYC cycles, then PAYOUT_GAP.
- PAYOUT_GAP: `hopper_on`=0 for GAP_CYC cycles. Decrement the coin count. If the result is > 0 go to PAYOUT_ON, else DONE.
- DONE: `done[w]`=1 for one cycle. Pointer becomes (w+1) mod N_REQ. Next state IDLE.
- `grant[w]`=1 from the first cycle after the IDLE decision through the DONE cycle inclusive.
- Latched values are used throughout the service. Changes or a drop of `req[w]`, `vend[w]` or `chg[w]` mid-service are ignored.
- A requester must deassert `req` at the clock edge ending its `done` cycle. IDLE then never sees a stale request.
- Only the pointer changes winner selection. Simultaneous requests are served strictly round-robin; with all N_REQ requesting, each is served once per N_REQ services.
- The cycle counter is sized $clog2(max(DISP_CYC, COIN_CYC, GAP_CYC)+1). The coin counter is 2 bits and never underflows.

## Timing
- Request seen high at edge k in IDLE: `grant`/`busy` high from cycle k+1.
  - With vend: `motor_on` high cycles k+1 … k+DISP_CYC.
- Service length in cycles after the IDLE decision: (vend ? DISP_CYC : 0) + coins*(COIN_CYC+GAP_CYC) + 1 (DONE).
- Back-to-back: at least one IDLE cycle between DONE and the next grant.
- `motor_on` and `hopper_on` are never high in the same cycle. Both are registered outputs with no combinational path from inputs.

## Structure
- Package `vend_pkg` holds:
  - the state enum;
  - the change-count type (2-bit);
  - constants COIN_NONE=0, COIN_MAX=3.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs `req` and pointer; outputs one-hot winner and valid. Instantiated once.

## Test plan
- Reset values: assert `rst`=0 mid-DISPENSE → all outputs 0 that cycle. Release → IDLE with pointer 0; `req`=0001 with vend=1, chg=0 → grant=0001 next cycle.
- Single requester, vend=1, chg=2 (defaults) → motor_on 8 cycles, then hopper_on 4 on / 2 off twice, then done[0] one cycle. Total 21 cycles; `busy` high for exactly those 21.
- vend=0, chg=0 on requester 2 → grant=0100 and done[2] in the same, single cycle; motor_on and hopper_on stay 0.
- All four request simultaneously, each vend=1, chg=1 → service order 0,1,2,3. Requester 0 requests again during service 3 → it is served fifth.
- Requester drops `req` and changes `chg` from 3 to 0 mid-PAYOUT → exactly 3 coin pulses are still issued, then done.
- Requesters 1 and 3 request, pointer=2 → requester 3 is granted first, then 1. `motor_on` and `hopper_on` are never high in the same cycle.

Source files
------------

// File: rtl/vend_service_arbiter_pkg.sv
// Shared types for the vending service arbiter.
// FSM states, coin-count type and helpers.
package vend_pkg;

   typedef enum logic [2:0] {
      IDLE,
      DISPENSE,
      PAYOUT_ON,
      PAYOUT_GAP,
      DONE
   } state_t;

   typedef logic [1:0] chg_t;

   localparam chg_t COIN_NONE = 2'd0;
   localparam chg_t COIN_MAX  = 2'd3;

   function automatic int max3(
      input int a,
      input int b,
      input int c
   );
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/vend_service_arbiter_if.sv
// Request/grant bundle between vending FSMs and
// the shared motor/hopper arbiter.
interface vend_service_arbiter_if #(
   parameter int N_REQ = 4
);

   logic [N_REQ-1:0]   req;
   logic [N_REQ-1:0]   vend;
   logic [2*N_REQ-1:0] chg;
   logic [N_REQ-1:0]   grant;
   logic [N_REQ-1:0]   done;
   logic               motor_on;
   logic               hopper_on;
   logic               busy;

   modport master (
      output req,
      output vend,
      output chg,
      input  grant,
      input  done,
      input  motor_on,
      input  hopper_on,
      input  busy
   );

   modport slave (
      input  req,
      input  vend,
      input  chg,
      output grant,
      output done,
      output motor_on,
      output hopper_on,
      output busy
   );

endinterface

// File: rtl/vend_service_arbiter_rr_pick.sv
// Round-robin priority picker: first set request
// at or above the pointer, wrapping to bit 0.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic          valid
);

   logic [N-1:0] mask;
   logic [N-1:0] hi;
   logic [N-1:0] src;

   // Prefer requests at/above ptr, else wrap; keep lowest set bit
   always_comb begin
      mask = '0;
      for (int i = 0; i < N; i++) begin
         mask[i] = (i >= int'(ptr));
      end
      hi    = req & mask;
      src   = (|hi) ? hi : req;
      valid = |req;
      win   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (src[i]) begin
            win    = '0;
            win[i] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vend_service_arbiter.sv
// Shares one dispense motor and one coin hopper
// among N vending FSMs, served round-robin.
module vend_service_arbiter
   import vend_pkg::*;
#(
   parameter int N_REQ    = 4,
   parameter int DISP_CYC = 8,
   parameter int COIN_CYC = 4,
   parameter int GAP_CYC  = 2
) (
   input logic                 clk,
   input logic                 rst,
   vend_service_arbiter_if.slave bus
);

   localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int CMAX = max3(DISP_CYC, COIN_CYC, GAP_CYC);
   localparam int CW   = $clog2(CMAX + 1);

   typedef logic [CW-1:0] cnt_t;

   localparam cnt_t DISP_LD = cnt_t'(DISP_CYC - 1);
   localparam cnt_t COIN_LD = cnt_t'(COIN_CYC - 1);
   localparam cnt_t GAP_LD  = cnt_t'(GAP_CYC - 1);
   localparam logic [IW-1:0] LAST = IW'(N_REQ - 1);

   state_t           state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    win_idx;
   chg_t             coins;
   cnt_t             cnt;
   logic [N_REQ-1:0] grant_q;
   logic [N_REQ-1:0] done_q;
   logic             motor_q;
   logic             hopper_q;
   logic             busy_q;

   logic [N_REQ-1:0] pick_win;
   logic             pick_valid;
   logic [IW-1:0]    pick_idx;
   logic             pick_vend;
   chg_t             pick_chg;

   rr_pick #(
      .N  (N_REQ),
      .IW (IW)
   ) u_pick (
      .req   (bus.req),
      .ptr   (ptr),
      .win   (pick_win),
      .valid (pick_valid)
   );

   // Index, vend flag and coin count of the picked requester
   always_comb begin
      pick_idx  = '0;
      pick_vend = 1'b0;
      pick_chg  = COIN_NONE;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_win[i]) begin
            pick_idx  = IW'(i);
            pick_vend = bus.vend[i];
            pick_chg  = bus.chg[2*i +: 2];
         end
      end
   end

   // Service FSM with registered motor/hopper/grant outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         ptr      <= '0;
         win_idx  <= '0;
         coins    <= COIN_NONE;
         cnt      <= '0;
         grant_q  <= '0;
         done_q   <= '0;
         motor_q  <= 1'b0;
         hopper_q <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         done_q <= '0;
         unique case (state)
            IDLE: begin
               if (pick_valid) begin
                  win_idx <= pick_idx;
                  coins   <= pick_chg;
                  grant_q <= pick_win;
                  busy_q  <= 1'b1;
                  if (pick_vend) begin
                     state   <= DISPENSE;
                     motor_q <= 1'b1;
                     cnt     <= DISP_LD;
                  end else if (pick_chg != COIN_NONE) begin
                     state    <= PAYOUT_ON;
                     hopper_q <= 1'b1;
                     cnt      <= COIN_LD;
                  end else begin
                     state  <= DONE;
                     done_q <= pick_win;
                  end
               end
            end
            DISPENSE: begin
               if (cnt == '0) begin
                  motor_q <= 1'b0;
                  if (coins != COIN_NONE) begin
                     state    <= PAYOUT_ON;
                     hopper_q <= 1'b1;
                     cnt      <= COIN_LD;
                  end else begin
                     state  <= DONE;
                     done_q <= grant_q;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            PAYOUT_ON: begin
               if (cnt == '0) begin
                  state    <= PAYOUT_GAP;
                  hopper_q <= 1'b0;
                  cnt      <= GAP_LD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            PAYOUT_GAP: begin
               if (cnt == '0) begin
                  if (coins > 2'd1) begin
                     coins    <= coins - 1'b1;
                     state    <= PAYOUT_ON;
                     hopper_q <= 1'b1;
                     cnt      <= COIN_LD;
                  end else begin
                     coins  <= COIN_NONE;
                     state  <= DONE;
                     done_q <= grant_q;
                  end
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE: begin
               state   <= IDLE;
               grant_q <= '0;
               busy_q  <= 1'b0;
               ptr     <= (win_idx == LAST) ? '0 : win_idx + 1'b1;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.motor_on  = motor_q;
   assign bus.hopper_on = hopper_q;
   assign bus.busy      = busy_q;

endmodule
